mc_ram_ctrl: RTL
================

MC_RAM_CTRL -- requirements
Module: mc_ram_ctrl

Interface
REQ-001 Parameter RD_WAIT, default 1: extra cycles the control store needs between strobe assertion and valid read data.
REQ-002 Parameter W_PULSE, default 2: cycles the write strobe is held low per word.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ld_start  input  1  begin load sequence; sampled only in IDLE.
REQ-006 ld_base  input  8  first control-store address of load; latched on ld_start.
REQ-007 ld_count  input  9  words to load, 0..256; latched on ld_start.
REQ-008 ld_valid  input  1  ld_byte valid.
REQ-009 ld_byte  input  8  load data byte, MSB-first within word.
REQ-010 ld_ready  output  1  block accepts a byte this cycle.
REQ-011 ld_busy  output  1  load sequence in progress.
REQ-012 ld_done  output  1  one-cycle pulse, load complete.
REQ-013 rd_req  input  1  microsequencer read request; level, held until rd_ack.
REQ-014 rd_addr  input  8  read address; latched on acceptance.
REQ-015 rd_ack  output  1  one-cycle pulse, rd_data valid.
REQ-016 rd_data  output  64  captured microinstruction; holds until next read.
REQ-017 ram_cs_n, ram_oe_n, ram_w_n  output  1 each  active-low control-store strobes.
REQ-018 ram_addr  output  8  control-store address.
REQ-019 ram_wdata  output  64  control-store write data.
REQ-020 ram_rdata  input  64  control-store read data.

Function
REQ-021 All outputs SHALL be registered; FSM states IDLE, FILL, SETUP, WPULSE, HOLD, READ.
REQ-022 IDLE: ld_start takes priority over rd_req on the same edge; ld_start -> FILL (ld_busy=1), or ld_done pulse with no writes if ld_count==0; else rd_req -> READ.
REQ-023 FILL: ld_ready=1; byte accepted when ld_valid&ld_ready; first byte -> ram_wdata[63:56], eighth -> [7:0]; accepted bytes need not be contiguous.
REQ-024 Edge accepting eighth byte -> SETUP: ld_ready=0, ram_cs_n=0, ram_w_n=1, ram_addr=current address, ram_wdata=assembled word.
REQ-025 SETUP lasts 1 cycle, then WPULSE: ram_w_n=0 for exactly W_PULSE cycles; address/data unchanged.
REQ-026 HOLD lasts 1 cycle: ram_w_n=1, ram_cs_n=0, address/data unchanged.
REQ-027 Leaving HOLD: ram_cs_n=1; address increments mod 256 (255 -> 0); remaining count decrements; nonzero -> FILL; zero -> IDLE with ld_busy=0, ld_done=1 for one cycle.
REQ-028 ram_oe_n SHALL remain 1 throughout any load state.
REQ-029 rd_ack SHALL stay 0 while ld_busy=1; pending rd_req waits.
REQ-030 READ entry edge: latch rd_addr to ram_addr, ram_cs_n=0, ram_oe_n=0, ram_w_n=1.
REQ-031 RD_WAIT+1 edges after entry: rd_data<=ram_rdata, rd_ack=1, ram_cs_n=1, ram_oe_n=1, return IDLE.
REQ-032 rd_req high during rd_ack cycle SHALL be accepted at the next edge (back-to-back reads, one idle-free cycle).
REQ-033 ld_start outside IDLE SHALL be ignored; ld_count>256 SHALL be treated as 256.
REQ-034 ram_cs_n and ram_oe_n SHALL never both be 0 while ram_w_n=0.

Reset
REQ-035 reset SHALL force IDLE, ram_cs_n=ram_oe_n=ram_w_n=1, ram_addr=0, ram_wdata=0, rd_data=0, rd_ack=ld_ready=ld_busy=ld_done=0 at the next edge.
REQ-036 reset mid-load or mid-read SHALL abort: partial word discarded, no further strobe edge, no ld_done/rd_ack.

Verification
REQ-037 Load ld_base=0x10, ld_count=1, bytes 01..08 back-to-back -> one ram_w_n low pulse of 2 cycles at addr 0x10, ram_wdata=0x0102030405060708, ld_done 1 cycle after HOLD.
REQ-038 Load ld_base=0xFF, ld_count=2 -> writes to 0xFF then 0x00.
REQ-039 Load 1 word then read 0x10, RD_WAIT=1 -> strobes low 2 cycles, rd_ack with rd_data=0x0102030405060708.
REQ-040 ld_start and rd_req same IDLE edge -> load runs first; rd_ack only after ld_done.
REQ-041 reset asserted during WPULSE -> ram_w_n=1, ram_cs_n=1 next edge; ld_done never pulses; ld_busy=0.
REQ-042 ld_count=0 -> ld_done next cycle, ram_w_n never low.

Source files
------------

// File: rtl/mc_ram_ctrl.sv
// Control-store RAM controller: byte-serial microcode loader plus single-word read port.
// Writes run FILL -> SETUP -> WPULSE (W_PULSE cycles) -> HOLD; reads hold strobes for RD_WAIT+1 cycles.
module mc_ram_ctrl #(
  parameter int RD_WAIT = 1,
  parameter int W_PULSE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_start,
  input  logic [7:0]  ld_base,
  input  logic [8:0]  ld_count,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_done,
  input  logic        rd_req,
  input  logic [7:0]  rd_addr,
  output logic        rd_ack,
  output logic [63:0] rd_data,
  output logic        ram_cs_n,
  output logic        ram_oe_n,
  output logic        ram_w_n,
  output logic [7:0]  ram_addr,
  output logic [63:0] ram_wdata,
  input  logic [63:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, FILL, SETUP, WPULSE, HOLD, READ} state_t;

  state_t     state;
  logic [8:0] remain;
  logic [2:0] byte_idx;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remain    <= '0;
      byte_idx  <= '0;
      cnt       <= '0;
      ld_ready  <= 1'b0;
      ld_busy   <= 1'b0;
      ld_done   <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
      ram_cs_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_w_n   <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ld_done <= 1'b0;
      rd_ack  <= 1'b0;
      case (state)
        IDLE: begin
          // A load request wins over a read request arriving on the same edge.
          if (ld_start) begin
            ram_addr <= ld_base;
            remain   <= (ld_count > 9'd256) ? 9'd256 : ld_count;
            byte_idx <= '0;
            if (ld_count == 9'd0) begin
              ld_done <= 1'b1;
            end else begin
              state    <= FILL;
              ld_busy  <= 1'b1;
              ld_ready <= 1'b1;
            end
          end else if (rd_req) begin
            state    <= READ;
            ram_addr <= rd_addr;
            ram_cs_n <= 1'b0;
            ram_oe_n <= 1'b0;
            ram_w_n  <= 1'b1;
            cnt      <= '0;
          end
        end
        FILL: begin
          if (ld_valid && ld_ready) begin
            // Shifting in from the bottom leaves the first byte in [63:56] after eight.
            ram_wdata <= {ram_wdata[55:0], ld_byte};
            byte_idx  <= byte_idx + 3'd1;
            if (byte_idx == 3'd7) begin
              state    <= SETUP;
              ld_ready <= 1'b0;
              ram_cs_n <= 1'b0;
              ram_w_n  <= 1'b1;
            end
          end
        end
        SETUP: begin
          state   <= WPULSE;
          ram_w_n <= 1'b0;
          cnt     <= '0;
        end
        WPULSE: begin
          if (cnt == 8'(W_PULSE - 1)) begin
            state   <= HOLD;
            ram_w_n <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          ram_cs_n <= 1'b1;
          ram_addr <= ram_addr + 8'd1;
          remain   <= remain - 9'd1;
          if (remain == 9'd1) begin
            state   <= IDLE;
            ld_busy <= 1'b0;
            ld_done <= 1'b1;
          end else begin
            state    <= FILL;
            ld_ready <= 1'b1;
            byte_idx <= '0;
          end
        end
        READ: begin
          if (cnt == 8'(RD_WAIT)) begin
            state    <= IDLE;
            rd_data  <= ram_rdata;
            rd_ack   <= 1'b1;
            ram_cs_n <= 1'b1;
            ram_oe_n <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
